// File: rtl/ins_mem_pkg.sv
// Shared types for the instruction memory loader.
// Provides the controller state enum and a bytes-per-word helper.
package ins_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ins_mem_array.sv
// Byte array: one 1-byte synchronous write port and a combinational
// k-byte little-endian read port (k = DATA_WIDTH/8).
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module ins_mem_array
    import ins_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [7:0]            wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int K = bytes_per_word(DATA_WIDTH);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Index wraps only for out-of-range fetches, whose data is discarded.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < K; i++) begin
            rdata[8*i +: 8] = mem[raddr + IDX_W'(i)];
        end
    end

endmodule

// File: rtl/ins_mem_loader.sv
// Instruction memory with serial byte loader and registered fetch port.
// Ports: clk, rst; load_start/load_base, ld_valid/ld_ready/ld_byte/ld_last,
// ld_count, ld_overflow; run; fetch_req/fetch_addr, fetch_valid/data/fault.
module ins_mem_loader
    import ins_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic [ADDR_WIDTH-1:0]  load_base,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [7:0]             ld_byte,
    input  logic                   ld_last,
    output logic [$clog2(DEPTH):0] ld_count,
    output logic                   ld_overflow,
    output logic                   run,
    input  logic                   fetch_req,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic                   fetch_valid,
    output logic [DATA_WIDTH-1:0]  fetch_data,
    output logic                   fetch_fault
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int K     = bytes_per_word(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IDX_W:0]      CNT_MAX = (IDX_W+1)'(DEPTH);

    state_t state, state_n;

    // Extra top bit: the pointer saturates instead of wrapping to 0.
    logic [ADDR_WIDTH:0]   ptr;
    logic [ADDR_WIDTH:0]   f_end;
    logic                  in_range;
    logic                  hs;
    logic                  we;
    logic                  accept;
    logic                  misalign;
    logic                  f_fault;
    logic                  restart;
    logic [DATA_WIDTH-1:0] rdata;

    assign in_range = ptr < DEPTH_W;
    assign hs       = (state == ST_LOAD) && ld_valid;
    assign we       = hs && in_range;
    assign accept   = (state == ST_RUN) && fetch_req;
    assign restart  = load_start && (state != ST_LOAD);
    assign f_end    = {1'b0, fetch_addr} + (ADDR_WIDTH+1)'(K);
    assign misalign = (fetch_addr % ADDR_WIDTH'(K)) != '0;
    assign f_fault  = misalign || (f_end > DEPTH_W);

    ins_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (ptr[IDX_W-1:0]),
        .wdata (ld_byte),
        .raddr (fetch_addr[IDX_W-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        ld_ready = 1'b0;
        run      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (load_start) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && ld_last) state_n = ST_RUN;
            end
            ST_RUN: begin
                run = 1'b1;
                if (load_start) state_n = ST_LOAD;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            ld_count    <= '0;
            ld_overflow <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_data  <= '0;
        end else begin
            if (restart) begin
                ptr         <= {1'b0, load_base};
                ld_count    <= '0;
                ld_overflow <= 1'b0;
            end else if (hs) begin
                if (!ptr[ADDR_WIDTH]) ptr <= ptr + 1'b1;
                if (in_range) begin
                    if (ld_count != CNT_MAX) ld_count <= ld_count + 1'b1;
                end else begin
                    ld_overflow <= 1'b1;
                end
            end
            fetch_valid <= accept;
            fetch_fault <= accept && f_fault;
            fetch_data  <= (accept && !f_fault) ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Self-checking bench for ins_mem_loader: directed load/fetch sequence
// with random data and addresses against a byte-array reference model.
module tb_ins_mem_loader;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int K     = DW / 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [7:0]    ld_byte = '0;
    logic          ld_last = 1'b0;
    logic [CW-1:0] ld_count;
    logic          ld_overflow;
    logic          run;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          fetch_fault;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  mdl [DEPTH];
    logic [7:0]  ld_q [$];
    logic [AW-1:0] fa_q [$];

    always #5 clk = ~clk;

    ins_mem_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_base   (load_base),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_byte     (ld_byte),
        .ld_last     (ld_last),
        .ld_count    (ld_count),
        .ld_overflow (ld_overflow),
        .run         (run),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_fault (fetch_fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected response for a fetch at addr, from the byte model.
    task automatic exp_fetch(input logic [AW-1:0] addr,
                             output logic flt, output logic [DW-1:0] d);
        longint a;
        a   = longint'(addr);
        flt = ((a % K) != 0) || (a + K > DEPTH);
        d   = '0;
        if (!flt) begin
            for (int k = 0; k < K; k++) d[8*k +: 8] = mdl[a + k];
        end
    endtask

    task automatic chk_resp(input string tag, input logic [AW-1:0] addr);
        logic flt;
        logic [DW-1:0] d;
        exp_fetch(addr, flt, d);
        chk({tag, "_v"}, 64'(fetch_valid), 64'd1);
        chk({tag, "_f"}, 64'(fetch_fault), 64'(flt));
        chk({tag, "_d"}, 64'(fetch_data), 64'(d));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_v"}, 64'(fetch_valid), 64'd0);
        chk({tag, "_f"}, 64'(fetch_fault), 64'd0);
        chk({tag, "_d"}, 64'(fetch_data), 64'd0);
    endtask

    // Loads ld_q from base; optional idle gaps carrying stray
    // load_start/fetch_req pulses; optional fetch alongside load_start.
    task automatic do_load(input logic [AW-1:0] base, input bit gaps,
                           input bit fetch_with_start);
        longint exp_cnt = 0;
        bit exp_ov = 1'b0;
        longint a;
        load_base  = base;
        load_start = 1'b1;
        fetch_req  = fetch_with_start;
        fetch_addr = '0;
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        if (fetch_with_start) chk_resp("reload_fetch", '0);
        chk("cnt_clr", 64'(ld_count), 64'd0);
        chk("ov_clr", 64'(ld_overflow), 64'd0);
        for (int i = 0; i < ld_q.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                ld_valid   = 1'b0;
                load_start = 1'($urandom_range(0, 1));
                load_base  = $urandom;
                fetch_req  = 1'b1;
                fetch_addr = '0;
                tick();
                load_start = 1'b0;
                fetch_req  = 1'b0;
                chk("gap_cnt", 64'(ld_count), 64'(exp_cnt));
                chk("gap_nofetch", 64'(fetch_valid), 64'd0);
            end
            chk("ld_ready", 64'(ld_ready), 64'd1);
            ld_valid = 1'b1;
            ld_byte  = ld_q[i];
            ld_last  = (i == ld_q.size() - 1);
            tick();
            a = longint'(base) + i;
            if (a < DEPTH) begin
                mdl[a] = ld_q[i];
                exp_cnt++;
            end else begin
                exp_ov = 1'b1;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("run_after_last", 64'(run), 64'd1);
        chk("ld_ready_run", 64'(ld_ready), 64'd0);
        chk("ld_count", 64'(ld_count), 64'(exp_cnt));
        chk("ld_overflow", 64'(ld_overflow), 64'(exp_ov));
    endtask

    // Back-to-back fetches of fa_q; one response per cycle, then quiet.
    task automatic fetch_burst(input string tag);
        for (int i = 0; i < fa_q.size(); i++) begin
            fetch_req  = 1'b1;
            fetch_addr = fa_q[i];
            tick();
            chk_resp(tag, fa_q[i]);
        end
        fetch_req = 1'b0;
        tick();
        chk_quiet({tag, "_end"});
    endtask

    task automatic fill_q(input int n);
        ld_q.delete();
        for (int i = 0; i < n; i++) ld_q.push_back(8'($urandom));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        // Reset state
        #2;
        chk("rst_ready", 64'(ld_ready), 64'd0);
        chk("rst_count", 64'(ld_count), 64'd0);
        chk("rst_ov", 64'(ld_overflow), 64'd0);
        chk("rst_run", 64'(run), 64'd0);
        chk_quiet("rst");
        tick();
        rst = 1'b0;
        tick();

        // Fetch while IDLE is ignored
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("idle_nofetch", 64'(fetch_valid), 64'd0);

        // First program: addi a0,x0,10
        ld_q = '{8'h13, 8'h05, 8'hA0, 8'h00};
        do_load(32'd0, 1'b0, 1'b0);
        fetch_req  = 1'b1;
        fetch_addr = '0;
        tick();
        fetch_req = 1'b0;
        chk("first_word", 64'(fetch_data), 64'h00A00513);
        chk_resp("first", '0);
        tick();
        chk_quiet("first_end");

        // Eight bytes, back-to-back fetches at 0 and 4
        fill_q(8);
        do_load(32'd0, 1'b0, 1'b1);
        fa_q = '{32'd0, 32'd4};
        fetch_burst("b2b");

        // Full random image with gaps and stray pulses
        fill_q(DEPTH);
        do_load(32'd0, 1'b1, 1'b0);
        fa_q = '{32'd2, 32'(DEPTH - 2), 32'h8000_0000, 32'(DEPTH),
                 32'(DEPTH - 4), 32'hFFFF_FFFC};
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) fa_q.push_back($urandom);
            else fa_q.push_back(32'($urandom_range(0, DEPTH - 1)) & ~32'(K - 1));
        end
        fetch_burst("rand");

        // Load running past the end of the array
        fill_q(4);
        do_load(32'(DEPTH - 2), 1'b0, 1'b0);
        fa_q = '{32'(DEPTH - 4)};
        fetch_burst("tail");

        // Load near the top of the address space: no wrap to low bytes
        fill_q(3);
        do_load(32'hFFFF_FFFE, 1'b0, 1'b0);
        fa_q = '{32'd0};
        fetch_burst("hi_base");

        // Reset with a response pending
        fetch_req  = 1'b1;
        fetch_addr = 32'd8;
        tick();
        fetch_req = 1'b0;
        chk("pend_v", 64'(fetch_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk_quiet("rst_pend");
        chk("rst_pend_run", 64'(run), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reset mid-load after two bytes
        load_base  = '0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'($urandom);
            tick();
            mdl[i] = ld_byte;
        end
        ld_valid = 1'b0;
        chk("mid_cnt", 64'(ld_count), 64'd2);
        rst = 1'b1;
        #1;
        chk("mrst_ready", 64'(ld_ready), 64'd0);
        chk("mrst_count", 64'(ld_count), 64'd0);
        chk("mrst_run", 64'(run), 64'd0);
        chk_quiet("mrst");
        tick();
        rst = 1'b0;
        tick();

        // Reload overwrites, then reload straight from RUN
        fill_q(8);
        do_load(32'd0, 1'b0, 1'b0);
        fa_q = '{32'd0, 32'd4};
        fetch_burst("reload1");
        fill_q(8);
        do_load(32'd4, 1'b1, 1'b1);
        fa_q = '{32'd4, 32'd8, 32'd0};
        fetch_burst("reload2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
